// File: rtl/nukv_pkg.sv
// Shared types and constants for the predicate-pipeline scheduler.
package nukv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRED  = 2'd1,
        ST_VALUE = 2'd2
    } sched_state_t;

    localparam logic REQ_GET  = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

    localparam int unsigned CREDIT_W = 8;

endpackage

// File: rtl/nukv_rr_arb2.sv
// Two-way round-robin picker; last_grant only moves when a packet finishes.
module nukv_rr_arb2
    import nukv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       update,
    input  logic       update_id,
    output logic       winner,
    output logic       eligible
);

    logic last_grant;

    // Reset to the scan requester so the first contended grant goes to gets.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_SCAN;
        end else if (update) begin
            last_grant <= update_id;
        end
    end

    always_comb begin
        winner   = REQ_GET;
        eligible = enable && (req != 2'b00);
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = REQ_SCAN;
        end
    end

endmodule

// File: rtl/nukv_pred_pipe_sched.sv
// Shares the predicate pipeline between get and scan requesters, one whole
// packet (predicate + value stream) at a time, bounded by in-flight credits.
module nukv_pred_pipe_sched
    import nukv_pkg::*;
#(
    parameter int unsigned MEMORY_WIDTH = 512,
    parameter int unsigned META_WIDTH   = 96,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [META_WIDTH+MEMORY_WIDTH-1:0] r0_pred_data,
    input  logic                               r0_pred_valid,
    output logic                               r0_pred_ready,
    input  logic [MEMORY_WIDTH-1:0]            r0_value_data,
    input  logic                               r0_value_valid,
    input  logic                               r0_value_last,
    input  logic                               r0_value_drop,
    output logic                               r0_value_ready,

    input  logic [META_WIDTH+MEMORY_WIDTH-1:0] r1_pred_data,
    input  logic                               r1_pred_valid,
    output logic                               r1_pred_ready,
    input  logic [MEMORY_WIDTH-1:0]            r1_value_data,
    input  logic                               r1_value_valid,
    input  logic                               r1_value_last,
    input  logic                               r1_value_drop,
    output logic                               r1_value_ready,

    output logic [META_WIDTH+MEMORY_WIDTH-1:0] pipe_pred_data,
    output logic                               pipe_pred_valid,
    output logic                               pipe_pred_scan,
    input  logic                               pipe_pred_ready,
    output logic [MEMORY_WIDTH-1:0]            pipe_value_data,
    output logic                               pipe_value_valid,
    output logic                               pipe_value_last,
    output logic                               pipe_value_drop,
    input  logic                               pipe_value_ready,

    input  logic                               pipe_out_valid,
    input  logic                               pipe_out_ready,
    input  logic                               pipe_out_last,

    output logic                               scan_on_outside,
    output logic [CREDIT_W-1:0]                inflight_count,
    output logic                               grant_id
);

    localparam int unsigned PRED_W = META_WIDTH + MEMORY_WIDTH;
    localparam logic [CREDIT_W-1:0] MAX_CREDITS = CREDIT_W'(MAX_INFLIGHT);

    sched_state_t state;

    logic winner;
    logic eligible;
    logic pred_grant;
    logic pred_hs;
    logic value_hs;
    logic pkt_done;
    logic credit_inc;
    logic credit_dec;

    nukv_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({r1_pred_valid, r0_pred_valid}),
        .enable    (inflight_count < MAX_CREDITS),
        .update    (pkt_done),
        .update_id (grant_id),
        .winner    (winner),
        .eligible  (eligible)
    );

    // Handshake qualifiers and the zero-latency value mux for the granted requester.
    always_comb begin
        pred_grant       = (state == ST_IDLE) && eligible;
        r0_pred_ready    = pred_grant && (winner == REQ_GET);
        r1_pred_ready    = pred_grant && (winner == REQ_SCAN);
        pred_hs          = pred_grant;

        pipe_value_data  = r0_value_data;
        pipe_value_last  = r0_value_last;
        pipe_value_drop  = r0_value_drop;
        pipe_value_valid = 1'b0;
        r0_value_ready   = 1'b0;
        r1_value_ready   = 1'b0;
        if (grant_id == REQ_SCAN) begin
            pipe_value_data = r1_value_data;
            pipe_value_last = r1_value_last;
            pipe_value_drop = r1_value_drop;
        end
        if (state == ST_VALUE) begin
            if (grant_id == REQ_SCAN) begin
                pipe_value_valid = r1_value_valid;
                r1_value_ready   = pipe_value_ready;
            end else begin
                pipe_value_valid = r0_value_valid;
                r0_value_ready   = pipe_value_ready;
            end
        end

        value_hs   = pipe_value_valid && pipe_value_ready;
        pkt_done   = value_hs && pipe_value_last;
        credit_inc = pipe_pred_valid && pipe_pred_ready;
        credit_dec = pipe_out_valid && pipe_out_ready && pipe_out_last;
    end

    // Packet FSM with registered predicate-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            pipe_pred_data  <= '0;
            pipe_pred_valid <= 1'b0;
            pipe_pred_scan  <= 1'b0;
            grant_id        <= REQ_GET;
            scan_on_outside <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pred_hs) begin
                        pipe_pred_data  <= (winner == REQ_SCAN) ? r1_pred_data : r0_pred_data;
                        pipe_pred_valid <= 1'b1;
                        pipe_pred_scan  <= winner;
                        grant_id        <= winner;
                        scan_on_outside <= (winner == REQ_SCAN);
                        state           <= ST_PRED;
                    end
                end
                ST_PRED: begin
                    if (pipe_pred_ready) begin
                        pipe_pred_valid <= 1'b0;
                        state           <= ST_VALUE;
                    end
                end
                ST_VALUE: begin
                    if (pkt_done) begin
                        scan_on_outside <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    pipe_pred_valid <= 1'b0;
                    scan_on_outside <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    // In-flight credits; a completion seen with nothing in flight is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_count <= '0;
        end else begin
            case ({credit_inc, credit_dec})
                2'b10:   inflight_count <= inflight_count + CREDIT_W'(1);
                2'b01:   if (inflight_count != '0) inflight_count <= inflight_count - CREDIT_W'(1);
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    logic [PRED_W-1:0] unused_width_anchor;
    assign unused_width_anchor = pipe_pred_data;

endmodule

// File: tb/tb_nukv_pred_pipe_sched.sv
// Directed bench for nukv_pred_pipe_sched with small widths and two credits.
module tb_nukv_pred_pipe_sched;

    localparam int unsigned MW = 16;
    localparam int unsigned XW = 8;
    localparam int unsigned PW = MW + XW;

    logic clk = 1'b0;
    logic rst;

    logic [PW-1:0] r0_pred_data, r1_pred_data;
    logic          r0_pred_valid, r1_pred_valid, r0_pred_ready, r1_pred_ready;
    logic [MW-1:0] r0_value_data, r1_value_data;
    logic          r0_value_valid, r0_value_last, r0_value_drop, r0_value_ready;
    logic          r1_value_valid, r1_value_last, r1_value_drop, r1_value_ready;
    logic [PW-1:0] pipe_pred_data;
    logic          pipe_pred_valid, pipe_pred_scan, pipe_pred_ready;
    logic [MW-1:0] pipe_value_data;
    logic          pipe_value_valid, pipe_value_last, pipe_value_drop, pipe_value_ready;
    logic          pipe_out_valid, pipe_out_ready, pipe_out_last;
    logic          scan_on_outside;
    logic [7:0]    inflight_count;
    logic          grant_id;

    // Manual completion taps, plus an echo mode completing a packet as each predicate enters.
    logic out_man, echo;
    assign pipe_out_valid = out_man | (echo & pipe_pred_valid & pipe_pred_ready);
    assign pipe_out_ready = pipe_out_valid;
    assign pipe_out_last  = pipe_out_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nukv_pred_pipe_sched #(.MEMORY_WIDTH(MW), .META_WIDTH(XW), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst),
        .r0_pred_data(r0_pred_data), .r0_pred_valid(r0_pred_valid), .r0_pred_ready(r0_pred_ready),
        .r0_value_data(r0_value_data), .r0_value_valid(r0_value_valid), .r0_value_last(r0_value_last),
        .r0_value_drop(r0_value_drop), .r0_value_ready(r0_value_ready),
        .r1_pred_data(r1_pred_data), .r1_pred_valid(r1_pred_valid), .r1_pred_ready(r1_pred_ready),
        .r1_value_data(r1_value_data), .r1_value_valid(r1_value_valid), .r1_value_last(r1_value_last),
        .r1_value_drop(r1_value_drop), .r1_value_ready(r1_value_ready),
        .pipe_pred_data(pipe_pred_data), .pipe_pred_valid(pipe_pred_valid), .pipe_pred_scan(pipe_pred_scan),
        .pipe_pred_ready(pipe_pred_ready),
        .pipe_value_data(pipe_value_data), .pipe_value_valid(pipe_value_valid), .pipe_value_last(pipe_value_last),
        .pipe_value_drop(pipe_value_drop), .pipe_value_ready(pipe_value_ready),
        .pipe_out_valid(pipe_out_valid), .pipe_out_ready(pipe_out_ready), .pipe_out_last(pipe_out_last),
        .scan_on_outside(scan_on_outside), .inflight_count(inflight_count), .grant_id(grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] beats [4];
        logic          ex;
        int            nacc;
        int            ncyc;

        rst = 1'b1;
        r0_pred_data = '0; r1_pred_data = '0; r0_pred_valid = 0; r1_pred_valid = 0;
        r0_value_data = '0; r1_value_data = '0;
        r0_value_valid = 0; r0_value_last = 0; r0_value_drop = 0;
        r1_value_valid = 0; r1_value_last = 0; r1_value_drop = 0;
        pipe_pred_ready = 0; pipe_value_ready = 0; out_man = 0; echo = 0;
        step(); step();

        // Reset state
        chk("rst_pred_valid", 32'(pipe_pred_valid), 0);
        chk("rst_pred_data", 32'(pipe_pred_data), 0);
        chk("rst_inflight", 32'(inflight_count), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_scan_out", 32'(scan_on_outside), 0);
        chk("rst_value_valid", 32'(pipe_value_valid), 0);
        rst = 1'b0;
        step();

        // Single get: predicate then three beats
        r0_pred_data = 24'hA11234; r0_pred_valid = 1;
        #1;
        chk("get_r0_pred_ready", 32'(r0_pred_ready), 1);
        chk("get_r1_pred_ready", 32'(r1_pred_ready), 0);
        step();
        chk("get_pred_valid", 32'(pipe_pred_valid), 1);
        chk("get_pred_data", 32'(pipe_pred_data), 32'hA11234);
        chk("get_pred_scan", 32'(pipe_pred_scan), 0);
        r0_pred_valid = 0; pipe_pred_ready = 1;
        r0_value_data = 16'h1111; r0_value_valid = 1;
        #1;
        chk("get_early_value_ready", 32'(r0_value_ready), 0);
        chk("get_early_value_valid", 32'(pipe_value_valid), 0);
        step();
        chk("get_inflight", 32'(inflight_count), 1);
        chk("get_pred_valid_drop", 32'(pipe_pred_valid), 0);
        pipe_pred_ready = 0; pipe_value_ready = 1;
        #1;
        chk("get_b1_valid", 32'(pipe_value_valid), 1);
        chk("get_b1_data", 32'(pipe_value_data), 32'h1111);
        chk("get_b1_last", 32'(pipe_value_last), 0);
        chk("get_b1_ready", 32'(r0_value_ready), 1);
        step();
        r0_value_data = 16'h2222;
        #1;
        chk("get_b2_data", 32'(pipe_value_data), 32'h2222);
        step();
        r0_value_data = 16'h3333; r0_value_last = 1; r0_value_drop = 1;
        #1;
        chk("get_b3_data", 32'(pipe_value_data), 32'h3333);
        chk("get_b3_last", 32'(pipe_value_last), 1);
        chk("get_b3_drop", 32'(pipe_value_drop), 1);
        step();
        r0_value_valid = 0; r0_value_last = 0; r0_value_drop = 0;
        #1;
        chk("get_idle_value_valid", 32'(pipe_value_valid), 0);
        chk("get_idle_inflight", 32'(inflight_count), 1);

        // Contention with a completion in every pred-handshake cycle (inflight stays 1)
        echo = 1; pipe_pred_ready = 1; pipe_value_ready = 1;
        r0_pred_data = 24'h0A0A0A; r1_pred_data = 24'h1B1B1B;
        r0_pred_valid = 1; r1_pred_valid = 1;
        r0_value_data = 16'h00A0; r1_value_data = 16'h01B1;
        r0_value_valid = 1; r0_value_last = 1; r1_value_valid = 1; r1_value_last = 1;
        for (int k = 0; k < 8; k++) begin
            ex = (k % 2 == 0);  // last grant was requester 0, so requester 1 leads
            #1;
            chk("cont_r0_pred_ready", 32'(r0_pred_ready), 32'(!ex));
            chk("cont_r1_pred_ready", 32'(r1_pred_ready), 32'(ex));
            step();
            chk("cont_grant", 32'(grant_id), 32'(ex));
            chk("cont_pred_scan", 32'(pipe_pred_scan), 32'(ex));
            chk("cont_scan_out", 32'(scan_on_outside), 32'(ex));
            chk("cont_pred_data", 32'(pipe_pred_data), ex ? 32'h1B1B1B : 32'h0A0A0A);
            if (k == 6) r1_pred_valid = 0;
            if (k == 7) r0_pred_valid = 0;
            step();
            chk("cont_inflight_same_cycle", 32'(inflight_count), 1);
            #1;
            chk("cont_value_data", 32'(pipe_value_data), ex ? 32'h01B1 : 32'h00A0);
            chk("cont_r0_value_ready", 32'(r0_value_ready), 32'(!ex));
            chk("cont_r1_value_ready", 32'(r1_value_ready), 32'(ex));
            step();
            chk("cont_scan_out_idle", 32'(scan_on_outside), 0);
        end
        r0_value_valid = 0; r0_value_last = 0; r1_value_valid = 0; r1_value_last = 0;
        echo = 0;

        // Decrement, then a spurious decrement at zero
        out_man = 1;
        step();
        chk("dec_to_zero", 32'(inflight_count), 0);
        step();
        chk("dec_saturate", 32'(inflight_count), 0);
        out_man = 0;

        // Credit limit of two with no completions
        r0_pred_data = 24'h0C0001; r0_pred_valid = 1;
        r0_value_data = 16'h0C0C; r0_value_valid = 1; r0_value_last = 1;
        for (int p = 0; p < 2; p++) begin
            #1;
            chk("lim_pred_ready", 32'(r0_pred_ready), 1);
            step(); step();
            chk("lim_inflight", 32'(inflight_count), 32'(p + 1));
            step();
        end
        #1;
        chk("lim_blocked_ready", 32'(r0_pred_ready), 0);
        step();
        chk("lim_blocked_pred_valid", 32'(pipe_pred_valid), 0);
        chk("lim_blocked_inflight", 32'(inflight_count), 2);
        out_man = 1;
        #1;
        chk("lim_still_blocked", 32'(r0_pred_ready), 0);
        step();
        out_man = 0;
        chk("lim_after_release", 32'(inflight_count), 1);
        #1;
        chk("lim_third_ready", 32'(r0_pred_ready), 1);
        step();
        chk("lim_third_pred_valid", 32'(pipe_pred_valid), 1);
        r0_pred_valid = 0;
        step();
        chk("lim_third_inflight", 32'(inflight_count), 2);
        step();
        r0_value_valid = 0; r0_value_last = 0;

        // Backpressure on a four-beat scan packet with an early next predicate
        out_man = 1;
        step(); step();
        out_man = 0;
        chk("bp_drained", 32'(inflight_count), 0);
        r1_pred_data = 24'h2B0001; r1_pred_valid = 1;
        #1;
        chk("bp_first_ready", 32'(r1_pred_ready), 1);
        step();
        r1_pred_data = 24'h2B0002;
        step();
        chk("bp_inflight", 32'(inflight_count), 1);
        beats[0] = 16'hB001; beats[1] = 16'hB002; beats[2] = 16'hB003; beats[3] = 16'hB004;
        nacc = 0; ncyc = 0;
        for (int c = 0; c < 16 && nacc < 4; c++) begin
            pipe_value_ready = (c % 2 == 0);
            r1_value_data = beats[nacc]; r1_value_valid = 1; r1_value_last = (nacc == 3);
            #1;
            chk("bp_pred_ready_held", 32'(r1_pred_ready), 0);
            chk("bp_value_data", 32'(pipe_value_data), 32'(beats[nacc]));
            chk("bp_value_ready", 32'(r1_value_ready), 32'(c % 2 == 0));
            ncyc++;
            if (r1_value_valid && r1_value_ready) nacc++;
            step();
        end
        chk("bp_beats", 32'(nacc), 4);
        chk("bp_cycles", 32'(ncyc), 7);
        r1_value_valid = 0; r1_value_last = 0;
        #1;
        chk("bp_next_grant", 32'(r1_pred_ready), 1);
        r1_pred_valid = 0;
        pipe_value_ready = 1;

        // Reset during the value stream after beat 2 of 4
        r0_pred_data = 24'hD00001; r0_pred_valid = 1;
        #1;
        chk("rmid_pred_ready", 32'(r0_pred_ready), 1);
        step();
        r0_pred_valid = 0;
        step();
        chk("rmid_inflight", 32'(inflight_count), 2);
        r0_value_data = 16'hD001; r0_value_valid = 1;
        step();
        r0_value_data = 16'hD002;
        step();
        rst = 1; r0_value_data = 16'hD003;
        step();
        chk("rmid_pred_valid", 32'(pipe_pred_valid), 0);
        chk("rmid_pred_data", 32'(pipe_pred_data), 0);
        chk("rmid_inflight_clr", 32'(inflight_count), 0);
        chk("rmid_scan_out", 32'(scan_on_outside), 0);
        #1;
        chk("rmid_value_valid", 32'(pipe_value_valid), 0);
        chk("rmid_value_ready", 32'(r0_value_ready), 0);
        rst = 0; r0_value_valid = 0;
        r0_pred_valid = 1; r1_pred_valid = 1;
        #1;
        chk("rmid_r0_first", 32'(r0_pred_ready), 1);
        chk("rmid_r1_wait", 32'(r1_pred_ready), 0);
        step();
        r0_pred_valid = 0; r1_pred_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nukv_pred_pipe_sched.md
Name: nukv_pred_pipe_sched

Overview:
- Scheduler in front of the predicate-evaluation pipeline. Shares one pipeline between two requesters: requester 0 (key lookups) and requester 1 (scans).
- Grants whole packets round-robin: one predicate word, then that requester's complete value stream up to value_last.
- Bounds the number of packets inside the pipeline with an in-flight credit counter.
- Drives the pipeline's pred_scan and scan_on_outside inputs.

Parameters:
- MEMORY_WIDTH, 512, value beat width and predicate payload width.
- META_WIDTH, 96, metadata width prepended to the predicate payload.
- MAX_INFLIGHT, 8, maximum packets accepted by the pipe but not yet emitted (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rN_pred_data  in  META_WIDTH+MEMORY_WIDTH  requester N predicate (N=0,1)
- rN_pred_valid  in  1  requester N predicate valid
- rN_pred_ready  out  1  requester N predicate accepted
- rN_value_data  in  MEMORY_WIDTH  requester N value beat
- rN_value_valid, rN_value_last, rN_value_drop  in  1 each  requester N value stream controls
- rN_value_ready  out  1  requester N value beat accepted
- pipe_pred_data  out  META_WIDTH+MEMORY_WIDTH  predicate to pipeline
- pipe_pred_valid  out  1  predicate valid
- pipe_pred_scan  out  1  1 when the predicate came from requester 1
- pipe_pred_ready  in  1  pipeline accepts predicate
- pipe_value_data  out  MEMORY_WIDTH  value beat to pipeline
- pipe_value_valid, pipe_value_last, pipe_value_drop  out  1 each  value stream controls to pipeline
- pipe_value_ready  in  1  pipeline accepts value beat
- pipe_out_valid, pipe_out_ready, pipe_out_last  in  1 each  monitor taps on the pipeline output handshake (observe only)
- scan_on_outside  out  1  scan packet currently granted
- inflight_count  out  8  current credit usage
- grant_id  out  1  requester currently or last granted

Behaviour:
- Reset values:
  - state=IDLE; all valid/ready outputs 0.
  - pipe_pred_data=0; inflight_count=0.
  - last_grant=1, so requester 0 wins first.
  - grant_id=0; scan_on_outside=0.
- FSM states: IDLE, PRED, VALUE.
- IDLE:
  - Eligible when inflight_count<MAX_INFLIGHT and at least one rN_pred_valid=1.
  - Winner is the valid requester that is not last_grant; if only one is valid, that one wins.
  - Winner's rN_pred_ready=1 (combinational, only when eligible). The other requester's ready is 0.
  - On that handshake: register pred_data into pipe_pred_data, set pipe_pred_scan=winner, set grant_id=winner, go to PRED.
  - If no requester is eligible, stay in IDLE.
- PRED:
  - pipe_pred_valid=1 with data held stable.
  - On pipe_pred_ready: inflight increments, go to VALUE.
  - Latency from predicate capture to pipe_pred_valid is 1 cycle.
- VALUE:
  - Zero-latency combinational mux: pipe_value_* = rG_value_*, and rG_value_ready = pipe_value_ready, where G=grant_id.
  - The other requester's value_ready=0.
  - On a handshake with last=1: last_grant<=G, go to IDLE. The next grant can be issued in the cycle after that.
  - The drop bit passes through unchanged; a packet with drop=1 still consumes a credit.
- Outside VALUE: pipe_value_valid=0 and both rN_value_ready=0. Value beats presented early are stalled, never lost.
- Credit counter:
  - +1 on a pipe_pred handshake.
  - −1 on pipe_out_valid&pipe_out_ready&pipe_out_last.
  - Both in the same cycle: unchanged.
  - Saturates at 0: a spurious decrement at 0 is ignored.
  - At MAX_INFLIGHT, no new grant is issued; a packet already in PRED or VALUE completes.
- scan_on_outside = (state!=IDLE) && grant_id==1.
- Reset mid-packet returns to IDLE immediately and clears credits. The upstream requester must also be reset.

Decomposition:
- Shared package (nukv_pkg): FSM state enum, requester-id constants REQ_GET=0 and REQ_SCAN=1, credit counter width.
- Natural sub-module: nukv_rr_arb2, a 2-way round-robin picker holding last_grant and producing winner/eligible.

Test Plan:
- Single get: r0 sends a predicate plus a 3-beat value. Required: pipe_pred_scan=0; pipe_pred_valid rises 1 cycle after capture; 3 beats appear unchanged with last on beat 3; inflight_count=1.
- Contention: r0 and r1 both hold 4 one-beat packets, pipe always ready. Required: grants alternate 0,1,0,1,…; scan_on_outside=1 only during r1 packets.
- Credit limit: MAX_INFLIGHT=2, pipe_out never completes, r0 offers 3 packets. Required: only 2 predicates pass and r0_pred_ready stays 0. One out_last handshake then lets the third through.
- Backpressure: pipe_value_ready toggles 1/0 during a 4-beat r1 packet, and r1 presents a new predicate early. Required: no beat is lost or duplicated; r1_pred_ready stays 0 until the packet's last beat is accepted.
- Simultaneous events: a pred handshake and an out_last in the same cycle with inflight=1. Required: inflight stays 1. A decrement at 0 keeps it at 0.
- Reset while in VALUE after beat 2 of 4: outputs return to reset values next cycle and inflight_count=0.
